// File: rtl/addr4u_result_monitor.sv
// addr4u_result_monitor
//
// Registered result stage for the 4-bit unsigned adder cores. Each accepted beat carries an
// operand pair and the adder's 5-bit sum. The stage checks that sum against a golden A+B,
// forwards the sum and a mismatch flag through a one-deep output register, and keeps vector
// and error statistics. With HALT_ON_ERR set, the first mismatching beat stops further
// intake until clr is pulsed.
//
// Parameters
//   CNT_W        width of vec_cnt / err_cnt (must be >= 2)
//   HALT_ON_ERR  1: stop intake on the first accepted mismatch
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   clr          synchronous clear of statistics and halt state
//   in_valid     operand/sum triple valid
//   in_ready     stage can accept this cycle (combinational)
//   op_a, op_b   adder operands
//   dut_sum      adder result under test
//   out_valid    registered result valid
//   out_ready    downstream accepts the result
//   out_sum      registered dut_sum
//   out_err      registered mismatch flag for out_sum
//   vec_cnt      saturating count of accepted beats
//   err_cnt      saturating count of accepted mismatching beats
//   fail_seen    sticky: some mismatch has been accepted
//   first_fail   {op_a, op_b, dut_sum} of the first accepted mismatch
//   halted       intake stopped after a mismatch

module addr4u_result_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned HALT_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_a,
    input  logic [3:0]       op_b,
    input  logic [4:0]       dut_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_sum,
    output logic             out_err,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_seen,
    output logic [12:0]      first_fail,
    output logic             halted
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic {
        StRun,
        StHalt
    } state_e;

    state_e state_q, state_d;

    // Datapath and statistics registers
    logic             out_valid_q, out_valid_d;
    logic [4:0]       out_sum_q, out_sum_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             fail_seen_q, fail_seen_d;
    logic [12:0]      first_fail_q, first_fail_d;

    logic [4:0] gold;
    logic       mismatch;
    logic       accept;
    logic       drain;

    // Golden sum kept at 5 bits so the carry out is compared too
    assign gold     = {1'b0, op_a} + {1'b0, op_b};
    assign mismatch = (dut_sum != gold);

    // Output register can take a new beat when empty or being drained this cycle
    assign in_ready = !clr && !halted && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    // ------------------------------------------------------------------
    // Halt FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (accept && mismatch && (HALT_ON_ERR != 0)) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (clr) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Halt FSM: outputs
    always_comb begin
        halted = (state_q == StHalt);
    end

    // ------------------------------------------------------------------
    // Output register next state
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_err_d   = out_err_q;
        if (accept) begin
            // Reload covers the simultaneous drain case, giving one beat per cycle
            out_valid_d = 1'b1;
            out_sum_d   = dut_sum;
            out_err_d   = mismatch;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Statistics next state; clr never coincides with accept since in_ready is low
    // ------------------------------------------------------------------
    always_comb begin
        vec_cnt_d    = vec_cnt_q;
        err_cnt_d    = err_cnt_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        if (clr) begin
            vec_cnt_d    = '0;
            err_cnt_d    = '0;
            fail_seen_d  = 1'b0;
            first_fail_d = '0;
        end else if (accept) begin
            if (vec_cnt_q != CntMax) begin
                vec_cnt_d = vec_cnt_q + CntOne;
            end
            if (mismatch) begin
                if (err_cnt_q != CntMax) begin
                    err_cnt_d = err_cnt_q + CntOne;
                end
                fail_seen_d = 1'b1;
                // Only the first mismatch since reset/clr is captured
                if (!fail_seen_q) begin
                    first_fail_d = {op_a, op_b, dut_sum};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_err_q    <= 1'b0;
            vec_cnt_q    <= '0;
            err_cnt_q    <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            out_err_q    <= out_err_d;
            vec_cnt_q    <= vec_cnt_d;
            err_cnt_q    <= err_cnt_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_err    = out_err_q;
    assign vec_cnt    = vec_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign fail_seen  = fail_seen_q;
    assign first_fail = first_fail_q;

endmodule

// File: doc/addr4u_result_monitor.md
# addr4u_result_monitor

Registered result stage placed directly downstream of the 4-bit unsigned adder cores. Each cycle it accepts one operand pair plus the adder's 5-bit sum over a valid/ready handshake. It checks the sum against an internal golden `A+B` and presents the registered result downstream. It keeps vector and error statistics for the fault-resilience campaigns, and can optionally halt intake on the first mismatch.

## Interface
- `CNT_W`, 16: width of `vec_cnt` and `err_cnt`; must be ≥ 2.
- `HALT_ON_ERR`, 0: when 1, the first mismatching vector stops intake until `clr`.

- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clr` input 1: synchronous clear of statistics and halt state.
- `in_valid` input 1: operand/sum triple valid.
- `in_ready` output 1: stage can accept this cycle.
- `op_a` input 4: adder operand A[3:0].
- `op_b` input 4: adder operand B[3:0].
- `dut_sum` input 5: adder result O[4:0].
- `out_valid` output 1: registered result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output 5: registered `dut_sum`.
- `out_err` output 1: registered mismatch flag for `out_sum`.
- `vec_cnt` output CNT_W: count of accepted vectors (saturating).
- `err_cnt` output CNT_W: count of accepted mismatching vectors (saturating).
- `fail_seen` output 1: sticky; set when any mismatch is accepted.
- `first_fail` output 13: `{op_a, op_b, dut_sum}` of the first mismatch.
- `halted` output 1: the state machine is in HALT.

## Operation
- Golden sum: `gold = {1'b0,op_a} + {1'b0,op_b}`, computed at 5 bits with no truncation. A mismatch is `dut_sum != gold` on all 5 bits.
- Handshake:
  - `in_ready = !clr && !halted && (!out_valid || out_ready)`, combinational.
  - Accept happens when `in_valid && in_ready`.
- On accept:
  - `out_sum <= dut_sum`, `out_err <= mismatch`, `out_valid <= 1`.
  - `vec_cnt` increments, holding at all-ones.
  - If mismatch: `err_cnt` increments (saturating) and `fail_seen <= 1`.
  - If mismatch and `fail_seen` was 0: `first_fail` captures the triple.
- Drain: `out_valid && out_ready` without a simultaneous accept gives `out_valid <= 0`. With a simultaneous accept, the register reloads (1/cycle throughput).
- While `out_valid && !out_ready`, `out_sum` and `out_err` hold stable.
- State machine, two states: RUN (reset state) and HALT.
  - RUN to HALT: `HALT_ON_ERR==1` and a mismatching vector is accepted.
  - HALT to RUN: only on `clr`.
  - In HALT, `in_ready` is 0. The output register still drains normally.
- `clr` behaviour:
  - Zeroes `vec_cnt`, `err_cnt`, `fail_seen` and `first_fail`, and forces RUN.
  - Does not touch `out_valid`, `out_sum` or `out_err`.
  - No accept can occur in a `clr` cycle because `in_ready` is 0.
- `HALT_ON_ERR==0`: HALT is unreachable and `halted` stays 0.

## Timing
- Reset (async, immediate): `out_valid=0`, `out_sum=0`, `out_err=0`, `vec_cnt=0`, `err_cnt=0`, `fail_seen=0`, `first_fail=0`, `halted=0`, state RUN. `in_ready` is then 1 unless `clr` is high.
- Reset asserted mid-stream discards the in-flight result; there is no drain.
- Latency: accept in cycle N gives `out_valid`/`out_sum`/`out_err` in cycle N+1. Counters, `fail_seen` and `first_fail` also update in cycle N+1.
- `halted` rises in cycle N+1 after a failing accept in cycle N. `in_ready` is 0 from N+1.
- Counters saturate: at all-ones, a further accept leaves the value unchanged. There is no wrap.
- All outputs except `in_ready` are registered.

## Test plan
- Reset, then accept `op_a=9`, `op_b=7`, `dut_sum=16` → next cycle `out_valid=1`, `out_sum=16`, `out_err=0`, `vec_cnt=1`, `err_cnt=0`, `fail_seen=0`.
- Mismatch and sticky capture:
  - Accept `15,15,dut_sum=0x1D` (gold `0x1E`) → `out_err=1`, `err_cnt=1`, `fail_seen=1`, `first_fail={4'hF,4'hF,5'h1D}`.
  - Then accept `1,1,dut_sum=0` → `err_cnt=2`, `first_fail` unchanged.
- Backpressure:
  - With `out_valid=1` and `out_ready=0` for 3 cycles → `in_ready=0` and `out_sum` stable.
  - Raise `out_ready` with `in_valid` high → accept in the same cycle and a new `out_sum` the next cycle, with no bubble.
- `HALT_ON_ERR=1`:
  - Mismatch accepted → `halted=1` next cycle and `in_ready=0` while `in_valid` stays high. The pending result still drains.
  - Pulse `clr` → `halted=0` and all counters and flags 0 in the following cycle.
- `CNT_W=4`: 20 back-to-back good vectors → `vec_cnt=15` and holding, `err_cnt=0`.
- Assert `rst` asynchronously between clock edges while `out_valid=1` → all outputs return to reset values before the next edge.
